stream_capture_trig: RTL and testbench

Triggered stream spy: a successor to the plain stream capture block. Records accepted beats (valid & ready) of a monitored stream into a circular block-RAM buffer. Supports arm/stop control, a programmable trigger (immediate, masked data match, or external pin) and a programmable post-trigger length, so the buffer holds pre- and post-trigger history. Sits beside any stream interface in the design; software configures it and reads the buffer over APB.

---
 rtl/stream_capture_trig.sv | 231 +++++++++++++++++++++++
 tb/tb_stream_capture_trig.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_trig.sv
// rtl/stream_capture_trig.sv - triggered stream spy: circular beat capture with APB readout
//
// Records accepted beats (din_valid & din_ready) of a monitored stream into a
// circular buffer. A programmable trigger (immediate, masked match, external
// pin) plus a post-trigger length leave pre- and post-trigger history in the
// buffer. Software controls it and reads the buffer over APB.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   din_data/din_valid/din_ready monitored stream (observe only)
//   trig_in                      external trigger, synchronous to clk
//   done                         high while capture is complete (DONE state)
//   cfg_paddr..cfg_pwdata        APB request; word address = cfg_paddr >> 2
//   cfg_pready/prdata/pslverr    APB response; pslverr is always 0
module stream_capture_trig #(
  parameter int DataBits = 8,
  parameter int MemDepth = 1024,
  localparam int MemAddrBits = $clog2(MemDepth)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DataBits-1:0]      din_data,
  input  logic                     din_valid,
  input  logic                     din_ready,
  input  logic                     trig_in,
  output logic                     done,
  input  logic [MemAddrBits+2:0]   cfg_paddr,
  input  logic                     cfg_psel,
  input  logic                     cfg_penable,
  input  logic                     cfg_pwrite,
  input  logic [31:0]              cfg_pwdata,
  output logic                     cfg_pready,
  output logic [31:0]              cfg_prdata,
  output logic                     cfg_pslverr
);

  localparam int PW = MemAddrBits + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]             mode;
  logic [DataBits-1:0]    match_val;
  logic [DataBits-1:0]    match_mask;
  logic [PW-1:0]          post_reg;     // value as written, for readback
  logic [PW-1:0]          post_eff;     // clamped 1..MemDepth, used by the FSM
  logic [PW-1:0]          post_eff_new;
  logic [MemAddrBits-1:0] trig_ptr;
  logic [MemAddrBits-1:0] wptr;
  logic [15:0]            count;
  logic                   wrapped;
  logic                   trig_pending;
  logic [PW-1:0]          remaining;

  logic [DataBits-1:0]    mem [MemDepth];
  logic [DataBits-1:0]    rd_q;

  // APB decode
  logic [MemAddrBits:0]   word;
  logic [MemAddrBits-1:0] idx;
  logic                   is_buf;
  logic                   setup;
  logic                   reg_wr;
  logic                   reg_rd;
  logic                   buf_rd;
  logic                   ctrl_wr;
  logic                   arm;
  logic                   stop;
  logic                   buf_pend;
  logic [31:0]            reg_rdata;
  logic                   unused_addr_bits;

  assign word    = cfg_paddr[MemAddrBits+2:2];
  assign idx     = word[MemAddrBits-1:0];
  assign is_buf  = ~word[MemAddrBits];
  assign setup   = cfg_psel & ~cfg_penable;
  assign reg_wr  = setup & cfg_pwrite & ~is_buf;
  assign reg_rd  = setup & ~cfg_pwrite & ~is_buf;
  assign buf_rd  = setup & ~cfg_pwrite & is_buf;
  assign ctrl_wr = reg_wr & (idx == MemAddrBits'(0));
  assign arm     = ctrl_wr & cfg_pwdata[0];
  assign stop    = ctrl_wr & cfg_pwdata[1];
  assign unused_addr_bits = &{1'b0, cfg_paddr[1:0]};

  assign cfg_pslverr = 1'b0;
  assign done        = (state == DONE);

  // Capture and trigger qualification
  logic beat;
  logic capture;
  logic hit;
  logic fire;

  assign beat    = din_valid & din_ready;
  assign capture = beat & ((state == ARMED) | (state == TRIGGERED));

  always_comb begin
    hit = 1'b0;
    case (mode)
      2'd0:    hit = 1'b1;
      2'd1:    hit = (((din_data ^ match_val) & match_mask) == '0);
      2'd2:    hit = trig_in | trig_pending;
      default: hit = 1'b0;
    endcase
  end

  assign fire = beat & (state == ARMED) & hit;

  // Clamp is taken from the full 32-bit write so that values which truncate
  // to zero in the readback register still behave as MemDepth.
  always_comb begin
    if (cfg_pwdata == 32'd0)
      post_eff_new = PW'(1);
    else if (cfg_pwdata > 32'(MemDepth))
      post_eff_new = PW'(MemDepth);
    else
      post_eff_new = cfg_pwdata[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARMED:     if (fire) state_next = (post_eff == PW'(1)) ? DONE : TRIGGERED;
      TRIGGERED: if (capture && remaining == PW'(1)) state_next = DONE;
      default:   state_next = state;
    endcase
    // Software control overrides the capture outcome; arm beats stop.
    if (arm)       state_next = ARMED;
    else if (stop) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode       <= 2'd0;
      match_val  <= '0;
      match_mask <= '0;
      post_reg   <= PW'(MemDepth / 2);
      post_eff   <= PW'(MemDepth / 2);
    end else if (reg_wr) begin
      case (idx)
        MemAddrBits'(2): mode       <= cfg_pwdata[1:0];
        MemAddrBits'(3): match_val  <= cfg_pwdata[DataBits-1:0];
        MemAddrBits'(4): match_mask <= cfg_pwdata[DataBits-1:0];
        MemAddrBits'(5): begin
          post_reg <= cfg_pwdata[PW-1:0];
          post_eff <= post_eff_new;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      count        <= '0;
      wrapped      <= 1'b0;
      trig_ptr     <= '0;
      trig_pending <= 1'b0;
      remaining    <= '0;
    end else begin
      if (capture) begin
        wptr  <= wptr + MemAddrBits'(1);
        count <= count + 16'd1;
        if (wptr == MemAddrBits'(MemDepth - 1)) wrapped <= 1'b1;
      end
      if (fire) begin
        trig_ptr     <= wptr;
        remaining    <= post_eff - PW'(1);
        trig_pending <= 1'b0;
      end else begin
        if (capture && state == TRIGGERED) remaining <= remaining - PW'(1);
        if (state == ARMED && trig_in && !beat) trig_pending <= 1'b1;
      end
      if (arm) begin
        wptr         <= '0;
        count        <= '0;
        wrapped      <= 1'b0;
        trig_pending <= 1'b0;
      end
    end
  end

  // Buffer RAM: write port for capture, registered read port for APB.
  always_ff @(posedge clk) begin
    if (capture) mem[wptr] <= din_data;
    rd_q <= mem[idx];
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (idx)
      MemAddrBits'(1): reg_rdata = {29'd0, wrapped, state};
      MemAddrBits'(2): reg_rdata = 32'(mode);
      MemAddrBits'(3): reg_rdata = 32'(match_val);
      MemAddrBits'(4): reg_rdata = 32'(match_mask);
      MemAddrBits'(5): reg_rdata = 32'(post_reg);
      MemAddrBits'(6): reg_rdata = 32'(trig_ptr);
      MemAddrBits'(7): reg_rdata = 32'(wptr);
      MemAddrBits'(8): reg_rdata = 32'(count);
      default:         reg_rdata = 32'd0;
    endcase
  end

  // Register accesses answer one cycle after setup; buffer reads need one
  // more cycle for the RAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pready <= 1'b0;
      cfg_prdata <= 32'd0;
      buf_pend   <= 1'b0;
    end else begin
      buf_pend   <= buf_rd;
      cfg_pready <= (setup & ~buf_rd) | buf_pend;
      if (buf_pend)    cfg_prdata <= 32'(rd_q);
      else if (reg_rd) cfg_prdata <= reg_rdata;
    end
  end

endmodule

// File: tb/tb_stream_capture_trig.sv
// tb/tb_stream_capture_trig.sv - self-checking bench for stream_capture_trig
//
// Instantiates the capture block with an 8-bit stream and a 16-deep buffer,
// runs a register table, then directed capture sequences.
module tb_stream_capture_trig;

  localparam int DB  = 8;
  localparam int MD  = 16;
  localparam int MAB = 4;
  localparam int AW  = MAB + 3;
  localparam int B   = MD;

  logic          clk = 1'b0;
  logic          rst;
  logic [DB-1:0] din_data;
  logic          din_valid;
  logic          din_ready;
  logic          trig_in;
  logic          done;
  logic [AW-1:0] cfg_paddr;
  logic          cfg_psel;
  logic          cfg_penable;
  logic          cfg_pwrite;
  logic [31:0]   cfg_pwdata;
  logic          cfg_pready;
  logic [31:0]   cfg_prdata;
  logic          cfg_pslverr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_capture_trig #(.DataBits(DB), .MemDepth(MD)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .trig_in(trig_in), .done(done),
    .cfg_paddr(cfg_paddr), .cfg_psel(cfg_psel), .cfg_penable(cfg_penable),
    .cfg_pwrite(cfg_pwrite), .cfg_pwdata(cfg_pwdata),
    .cfg_pready(cfg_pready), .cfg_prdata(cfg_prdata), .cfg_pslverr(cfg_pslverr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input int word, input logic [31:0] data);
    int lat;
    cfg_paddr = AW'(word * 4); cfg_pwdata = data;
    cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b1;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    lat = 1;
    while (!cfg_pready && lat < 10) begin @(posedge clk); #1; lat++; end
    check("wr_ready", 32'(cfg_pready), 32'd1);
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
  endtask

  task automatic apb_read(input int word, output logic [31:0] data, output int lat);
    cfg_paddr = AW'(word * 4);
    cfg_psel = 1'b1; cfg_penable = 1'b0; cfg_pwrite = 1'b0;
    @(posedge clk); #1;
    cfg_penable = 1'b1;
    lat = 1;
    while (!cfg_pready && lat < 10) begin @(posedge clk); #1; lat++; end
    data = cfg_prdata;
    if (!cfg_pready) lat = 99;
    @(posedge clk); #1;
    cfg_psel = 1'b0; cfg_penable = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int word, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    apb_read(word, d, lat);
    check(name, d, exp);
    check({name, "_lat"}, 32'(lat), (word < B) ? 32'd2 : 32'd1);
  endtask

  task automatic beat(input logic [DB-1:0] d, input logic t);
    din_data = d; din_valid = 1'b1; din_ready = 1'b1; trig_in = t;
    @(posedge clk); #1;
    din_valid = 1'b0; din_ready = 1'b0; trig_in = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    int          word;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [31:0] d;
    int lat;

    rst = 1'b1; din_data = '0; din_valid = 1'b0; din_ready = 1'b0; trig_in = 1'b0;
    cfg_paddr = '0; cfg_psel = 1'b0; cfg_penable = 1'b0; cfg_pwrite = 1'b0; cfg_pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_pready", 32'(cfg_pready), 32'd0);
    check("rst_prdata", cfg_prdata, 32'd0);
    check("pslverr", 32'(cfg_pslverr), 32'd0);
    rst = 1'b0;

    // Register reset values, RW truncation, RO/unmapped behaviour
    tbl[0]  = '{1'b0, B+1, 32'd0, 32'd0};
    tbl[1]  = '{1'b0, B+2, 32'd0, 32'd0};
    tbl[2]  = '{1'b0, B+3, 32'd0, 32'd0};
    tbl[3]  = '{1'b0, B+4, 32'd0, 32'd0};
    tbl[4]  = '{1'b0, B+5, 32'd0, 32'd8};
    tbl[5]  = '{1'b0, B+6, 32'd0, 32'd0};
    tbl[6]  = '{1'b0, B+7, 32'd0, 32'd0};
    tbl[7]  = '{1'b0, B+8, 32'd0, 32'd0};
    tbl[8]  = '{1'b0, B+0, 32'd0, 32'd0};
    tbl[9]  = '{1'b0, B+9, 32'd0, 32'd0};
    tbl[10] = '{1'b1, B+2, 32'd7, 32'd0};
    tbl[11] = '{1'b0, B+2, 32'd0, 32'd3};
    tbl[12] = '{1'b1, B+3, 32'h1A5, 32'd0};
    tbl[13] = '{1'b0, B+3, 32'd0, 32'hA5};
    tbl[14] = '{1'b1, B+5, 32'd37, 32'd0};
    tbl[15] = '{1'b0, B+5, 32'd0, 32'd5};
    tbl[16] = '{1'b1, B+1, 32'hFF, 32'd0};
    tbl[17] = '{1'b0, B+1, 32'd0, 32'd0};
    tbl[18] = '{1'b1, B+9, 32'h12, 32'd0};
    tbl[19] = '{1'b0, B+9, 32'd0, 32'd0};
    tbl[20] = '{1'b0, B+15, 32'd0, 32'd0};
    tbl[21] = '{1'b1, B+2, 32'd0, 32'd0};
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) apb_write(tbl[i].word, tbl[i].data);
      else rd_chk($sformatf("tbl%0d", i), tbl[i].word, tbl[i].exp);
    end

    // Mode 0, POST_COUNT 4
    apb_write(B+5, 4);
    apb_write(B+0, 1);
    rd_chk("s1_status_armed", B+1, 1);
    din_data = 8'hEE; din_valid = 1'b1; din_ready = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      beat(DB'(i), 1'b0);
      if (i == 2) check("s1_done_early", 32'(done), 32'd0);
      if (i == 3) check("s1_done", 32'(done), 32'd1);
    end
    check("s1_done_hold", 32'(done), 32'd1);
    rd_chk("s1_status", B+1, 3);
    rd_chk("s1_trig_ptr", B+6, 0);
    rd_chk("s1_wptr", B+7, 4);
    rd_chk("s1_count", B+8, 4);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("s1_buf%0d", i), i, 32'(i));

    // Mode 1, match 0x5A, POST_COUNT 3, counting data with wrap
    apb_write(B+3, 32'h5A);
    apb_write(B+4, 32'hFF);
    apb_write(B+2, 1);
    apb_write(B+5, 3);
    apb_write(B+0, 1);
    for (int i = 0; i < 128; i++) beat(DB'(i), 1'b0);
    rd_chk("s2_status", B+1, 7);
    rd_chk("s2_trig_ptr", B+6, 32'h5A % 16);
    rd_chk("s2_wptr", B+7, (32'h5A + 3) % 16);
    rd_chk("s2_count", B+8, 32'h5C + 1);
    rd_chk("s2_buf_trig", 10, 32'h5A);
    rd_chk("s2_buf_last", 12, 32'h5C);
    rd_chk("s2_buf_oldest", 13, 32'h4D);

    // Mode 2, trig_in while idle stream, next beat is trigger
    apb_write(B+2, 2);
    apb_write(B+5, 2);
    apb_write(B+0, 1);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    rd_chk("s3_status_armed", B+1, 1);
    trig_in = 1'b1;
    @(posedge clk); #1;
    trig_in = 1'b0;
    check("s3_pending_set", 32'(dut.trig_pending), 32'd1);
    beat(8'h33, 1'b0);
    check("s3_pending_clr", 32'(dut.trig_pending), 32'd0);
    rd_chk("s3_status_trig", B+1, 2);
    rd_chk("s3_trig_ptr", B+6, 2);
    beat(8'h44, 1'b0);
    rd_chk("s3_status_done", B+1, 3);
    rd_chk("s3_wptr", B+7, 4);
    rd_chk("s3_buf_trig", 2, 32'h33);

    // Stop mid-ARMED, then re-arm; arm wins over stop
    apb_write(B+2, 3);
    apb_write(B+0, 1);
    for (int i = 0; i < 5; i++) beat(DB'(8'hA0 + i), 1'b0);
    rd_chk("s4_status_armed", B+1, 1);
    rd_chk("s4_wptr_armed", B+7, 5);
    apb_write(B+0, 2);
    rd_chk("s4_status_idle", B+1, 0);
    for (int i = 0; i < 3; i++) beat(DB'(8'hE0 + i), 1'b0);
    rd_chk("s4_wptr_hold", B+7, 5);
    rd_chk("s4_count_hold", B+8, 5);
    rd_chk("s4_buf_unwritten", 5, 32'h55);
    apb_write(B+0, 1);
    rd_chk("s4_rearm_wptr", B+7, 0);
    rd_chk("s4_rearm_count", B+8, 0);
    apb_write(B+0, 2);
    apb_write(B+0, 3);
    rd_chk("s4_arm_wins", B+1, 1);

    // POST_COUNT boundaries: 0 acts as 1, 2*MemDepth acts as MemDepth
    apb_write(B+2, 0);
    apb_write(B+5, 0);
    rd_chk("s5_post0_read", B+5, 0);
    apb_write(B+0, 1);
    beat(8'h77, 1'b0);
    rd_chk("s5_post0_status", B+1, 3);
    rd_chk("s5_post0_wptr", B+7, 1);
    apb_write(B+5, 2 * MD);
    rd_chk("s5_post32_read", B+5, 0);
    apb_write(B+0, 1);
    for (int i = 0; i < 15; i++) beat(DB'(8'h80 + i), 1'b0);
    rd_chk("s5_post32_status_trig", B+1, 2);
    beat(8'h8F, 1'b0);
    rd_chk("s5_post32_status_done", B+1, 7);
    rd_chk("s5_post32_wptr", B+7, 0);

    // rst during TRIGGERED, then a buffer read with its latency
    apb_write(B+2, 2);
    apb_write(B+5, 8);
    apb_write(B+0, 1);
    beat(8'hC1, 1'b0);
    beat(8'hC2, 1'b0);
    beat(8'hC3, 1'b1);
    rd_chk("s6_status_trig", B+1, 2);
    rd_chk("s6_trig_ptr", B+6, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    check("s6_rst_state", 32'(dut.state), 32'd0);
    check("s6_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    rd_chk("s6_status", B+1, 0);
    rd_chk("s6_wptr", B+7, 0);
    rd_chk("s6_trig_ptr_rst", B+6, 0);
    rd_chk("s6_count", B+8, 0);
    rd_chk("s6_mode", B+2, 0);
    rd_chk("s6_match_val", B+3, 0);
    rd_chk("s6_post", B+5, 8);
    apb_write(B+0, 1);
    beat(8'hD1, 1'b0);
    beat(8'hD2, 1'b0);
    apb_read(1, d, lat);
    check("s6_buf_data", d, 32'hD2);
    check("s6_buf_lat", 32'(lat), 32'd2);
    check("s6_pready_pulse", 32'(cfg_pready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
